// File: rtl/pong_match_ctrl.sv
// Two-player Pong match sequencer: synchronizes point/start lines, arbitrates
// points, drives score-counter pulses, serve hold-off, win detection and blink.
module pong_match_ctrl #(
    parameter int SYNC_STAGES  = 2,
    parameter int HOLD_CYCLES  = 50000000,
    parameter int WIN_SCORE    = 11,
    parameter int BLINK_CYCLES = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pt_a_in,
    input  logic       pt_b_in,
    input  logic       start_in,
    output logic       incr_a,
    output logic       incr_b,
    output logic       score_clr,
    output logic       serve_en,
    output logic       serve_dir,
    output logic       game_over,
    output logic       winner,
    output logic       disp_blank,
    output logic [1:0] state_o
);

    localparam int SCORE_W = $clog2(WIN_SCORE + 1);
    localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_LAST = SCORE_W'(WIN_SCORE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        PLAY = 2'b10,
        OVER = 2'b11
    } state_t;

    // Bit 0 = point A, bit 1 = point B, bit 2 = start.
    logic [2:0] async_vec;
    logic [2:0] level;
    logic [2:0] prev_reg;
    logic [2:0] evt;

    assign async_vec = {start_in, pt_b_in, pt_a_in};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] sync_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_vec[gi]};
                end
            end
            assign level[gi] = sync_reg[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_reg <= '0;
        end else begin
            prev_reg <= level;
        end
    end

    assign evt = level & ~prev_reg;

    state_t               state_reg;
    logic [SCORE_W-1:0]   score_a_reg;
    logic [SCORE_W-1:0]   score_b_reg;
    logic [HOLD_W-1:0]    hold_cnt_reg;
    logic [BLINK_W-1:0]   blink_cnt_reg;
    logic                 incr_a_reg;
    logic                 incr_b_reg;
    logic                 score_clr_reg;
    logic                 serve_en_reg;
    logic                 serve_dir_reg;
    logic                 game_over_reg;
    logic                 winner_reg;
    logic                 disp_blank_reg;

    // Simultaneous points go to the trailing player; ties favour A.
    logic grant_a;
    logic grant_b;
    assign grant_a = evt[0] & (~evt[1] | (score_a_reg <= score_b_reg));
    assign grant_b = evt[1] & ~grant_a;

    logic [SCORE_W-1:0] score_a_inc;
    logic [SCORE_W-1:0] score_b_inc;
    assign score_a_inc = (score_a_reg == SCORE_MAX) ? score_a_reg : score_a_reg + 1'b1;
    assign score_b_inc = (score_b_reg == SCORE_MAX) ? score_b_reg : score_b_reg + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            score_a_reg    <= '0;
            score_b_reg    <= '0;
            hold_cnt_reg   <= '0;
            blink_cnt_reg  <= '0;
            incr_a_reg     <= 1'b0;
            incr_b_reg     <= 1'b0;
            score_clr_reg  <= 1'b0;
            serve_en_reg   <= 1'b0;
            serve_dir_reg  <= 1'b0;
            game_over_reg  <= 1'b0;
            winner_reg     <= 1'b0;
            disp_blank_reg <= 1'b0;
        end else begin
            incr_a_reg    <= 1'b0;
            incr_b_reg    <= 1'b0;
            score_clr_reg <= 1'b0;
            if (evt[2]) begin
                // Start or restart from any state; outranks a same-cycle point.
                score_clr_reg  <= 1'b1;
                score_a_reg    <= '0;
                score_b_reg    <= '0;
                serve_dir_reg  <= 1'b0;
                serve_en_reg   <= 1'b0;
                game_over_reg  <= 1'b0;
                disp_blank_reg <= 1'b0;
                hold_cnt_reg   <= HOLD_LOAD;
                state_reg      <= HOLD;
            end else begin
                case (state_reg)
                    IDLE: begin
                    end
                    HOLD: begin
                        if (hold_cnt_reg == '0) begin
                            state_reg    <= PLAY;
                            serve_en_reg <= 1'b1;
                        end else begin
                            hold_cnt_reg <= hold_cnt_reg - 1'b1;
                        end
                    end
                    PLAY: begin
                        if (grant_a || grant_b) begin
                            serve_en_reg  <= 1'b0;
                            incr_a_reg    <= grant_a;
                            incr_b_reg    <= grant_b;
                            serve_dir_reg <= grant_a;
                            if (grant_a) begin
                                score_a_reg <= score_a_inc;
                            end else begin
                                score_b_reg <= score_b_inc;
                            end
                            if ((grant_a && score_a_reg == SCORE_LAST) ||
                                (grant_b && score_b_reg == SCORE_LAST)) begin
                                state_reg      <= OVER;
                                game_over_reg  <= 1'b1;
                                winner_reg     <= grant_b;
                                disp_blank_reg <= 1'b0;
                                blink_cnt_reg  <= BLINK_LOAD;
                            end else begin
                                state_reg    <= HOLD;
                                hold_cnt_reg <= HOLD_LOAD;
                            end
                        end
                    end
                    OVER: begin
                        if (blink_cnt_reg == '0) begin
                            disp_blank_reg <= ~disp_blank_reg;
                            blink_cnt_reg  <= BLINK_LOAD;
                        end else begin
                            blink_cnt_reg <= blink_cnt_reg - 1'b1;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign incr_a     = incr_a_reg;
    assign incr_b     = incr_b_reg;
    assign score_clr  = score_clr_reg;
    assign serve_en   = serve_en_reg;
    assign serve_dir  = serve_dir_reg;
    assign game_over  = game_over_reg;
    assign winner     = winner_reg;
    assign disp_blank = disp_blank_reg;
    assign state_o    = state_reg;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Randomized match bench for pong_match_ctrl, checked cycle by cycle against
// an event-time reference model of the match rules.
module tb_pong_match_ctrl;

    localparam int S = 2;
    localparam int H = 4;
    localparam int W = 3;
    localparam int B = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pt_a_in = 1'b0;
    logic       pt_b_in = 1'b0;
    logic       start_in = 1'b0;
    logic       incr_a, incr_b, score_clr, serve_en, serve_dir;
    logic       game_over, winner, disp_blank;
    logic [1:0] state_o;

    pong_match_ctrl #(
        .SYNC_STAGES (S),
        .HOLD_CYCLES (H),
        .WIN_SCORE   (W),
        .BLINK_CYCLES(B)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pt_a_in   (pt_a_in),
        .pt_b_in   (pt_b_in),
        .start_in  (start_in),
        .incr_a    (incr_a),
        .incr_b    (incr_b),
        .score_clr (score_clr),
        .serve_en  (serve_en),
        .serve_dir (serve_dir),
        .game_over (game_over),
        .winner    (winner),
        .disp_blank(disp_blank),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, obs, exp_v);
        end
    endtask

    // Reference model: sampled input history plus absolute edge times of
    // phase entry. Phase: 0 idle, 1 hold-off, 2 rally, 3 match over.
    bit qa[$];
    bit qb[$];
    bit qs[$];
    int cyc, m_phase, m_sa, m_sb, m_dir, m_winner, hold_entry, over_entry;
    bit m_incr_a, m_incr_b, m_clr;

    function automatic void model_reset();
        qa = {};
        qb = {};
        qs = {};
        for (int i = 0; i <= S; i++) begin
            qa.push_back(1'b0);
            qb.push_back(1'b0);
            qs.push_back(1'b0);
        end
        cyc = 0; m_phase = 0; m_sa = 0; m_sb = 0; m_dir = 0; m_winner = 0;
        hold_entry = 0; over_entry = 0;
        m_incr_a = 0; m_incr_b = 0; m_clr = 0;
    endfunction

    // An input acts at edge k when it was sampled high at edge k-S and low at k-S-1.
    function automatic void model_step(input bit a, input bit b, input bit s);
        bit ea, eb, es, a_wins_pt;
        ea = qa[qa.size()-S] && !qa[qa.size()-S-1];
        eb = qb[qb.size()-S] && !qb[qb.size()-S-1];
        es = qs[qs.size()-S] && !qs[qs.size()-S-1];
        qa.push_back(a);
        qb.push_back(b);
        qs.push_back(s);
        m_incr_a = 0; m_incr_b = 0; m_clr = 0;
        if (es) begin
            m_clr = 1; m_sa = 0; m_sb = 0; m_dir = 0;
            m_phase = 1; hold_entry = cyc;
        end else if (m_phase == 1) begin
            if (cyc - hold_entry == H) m_phase = 2;
        end else if (m_phase == 2 && (ea || eb)) begin
            if (ea && eb) a_wins_pt = (m_sa <= m_sb);
            else          a_wins_pt = ea;
            if (a_wins_pt) begin
                m_incr_a = 1; m_sa++; m_dir = 1;
            end else begin
                m_incr_b = 1; m_sb++; m_dir = 0;
            end
            if (m_sa == W || m_sb == W) begin
                m_phase = 3; over_entry = cyc; m_winner = a_wins_pt ? 0 : 1;
            end else begin
                m_phase = 1; hold_entry = cyc;
            end
        end
        cyc++;
    endfunction

    task automatic compare_all();
        int blank_exp;
        blank_exp = (m_phase == 3) ? (((cyc - 1 - over_entry) / B) % 2) : 0;
        check("incr_a", incr_a, m_incr_a);
        check("incr_b", incr_b, m_incr_b);
        check("score_clr", score_clr, m_clr);
        check("serve_en", serve_en, (m_phase == 2) ? 1 : 0);
        check("serve_dir", serve_dir, m_dir[7:0]);
        check("game_over", game_over, (m_phase == 3) ? 1 : 0);
        check("disp_blank", disp_blank, blank_exp[7:0]);
        check("state_o", state_o, m_phase[7:0]);
        if (m_phase == 3) check("winner", winner, m_winner[7:0]);
        if (m_clr)    $display("[TB] t=%0t score_clr", $time);
        if (m_incr_a) $display("[TB] t=%0t incr_a score %0d-%0d", $time, m_sa, m_sb);
        if (m_incr_b) $display("[TB] t=%0t incr_b score %0d-%0d", $time, m_sa, m_sb);
    endtask

    // Called at a falling edge: drive inputs, advance model, then check.
    task automatic tick(input bit a, input bit b, input bit s);
        pt_a_in  = a;
        pt_b_in  = b;
        start_in = s;
        model_step(a, b, s);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        #2;
        rst      = 1'b1;
        pt_a_in  = 1'b0;
        pt_b_in  = 1'b0;
        start_in = 1'b0;
        #1;
        check("rst_outputs", {incr_a, incr_b, score_clr, serve_en,
                              serve_dir, game_over, winner, disp_blank}, 8'h00);
        check("rst_state", state_o, 8'h00);
        $display("[TB] t=%0t reset asserted", $time);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic point_a();
        tick(1'b1, 1'b0, 1'b0);
        idle_ticks(9);
    endtask

    initial begin
        bit ra, rb, rs;
        @(negedge clk);
        do_reset();

        // Start, hold-off, then rally.
        tick(1'b0, 1'b0, 1'b1);
        idle_ticks(8);
        // A held high for 20 cycles yields one point only.
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b0);
        idle_ticks(6);
        // Simultaneous at 1-0 goes to B, then at 1-1 goes to A.
        tick(1'b1, 1'b1, 1'b0);
        idle_ticks(9);
        tick(1'b1, 1'b1, 1'b0);
        idle_ticks(9);
        // A reaches 3 -> match over, B points ignored while blinking.
        point_a();
        tick(1'b0, 1'b1, 1'b0);
        idle_ticks(4);
        tick(1'b0, 1'b1, 1'b0);
        idle_ticks(6);
        // Restart from OVER, B pulse during hold-off is discarded.
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        idle_ticks(8);
        // Reset mid-hold.
        tick(1'b0, 1'b0, 1'b1);
        idle_ticks(3);
        do_reset();
        // Play to OVER, then reset while blinking.
        tick(1'b0, 1'b0, 1'b1);
        idle_ticks(8);
        point_a();
        point_a();
        point_a();
        idle_ticks(3);
        do_reset();

        // Randomized phase.
        ra = 0; rb = 0; rs = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                ra = 0; rb = 0; rs = 0;
            end
            if ($urandom_range(0, 19) == 0 && !ra && !rb) begin
                ra = 1; rb = 1;
            end else begin
                if ($urandom_range(0, 7) == 0) ra = !ra;
                if ($urandom_range(0, 7) == 0) rb = !rb;
            end
            if ($urandom_range(0, 99) == 0) rs = !rs;
            tick(ra, rb, rs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
